// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-port SRAM arbiter: FSM encodings, port
// identifiers, default widths and the grant-selection rule.
package sram_arb_pkg;

   // Default bus widths; the top module exposes them as parameters.
   localparam int ADDR_W_DEF = 15;
   localparam int DATA_W_DEF = 32;

   // FSM state encodings.
   typedef logic [1:0] arb_state_t;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Port identifiers, also the encoding of the grant output.
   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   // Width of the read-latency down-counter (RD_LAT - 1 fits in 0..6).
   localparam int CNT_W = 3;

   // Choose the winning port among the eligible ones. With round robin,
   // contention goes to the port that did not win last time; otherwise A
   // always wins. The result is only meaningful when at least one port is
   // eligible.
   function automatic logic pick_port(input logic elig_a,
                                      input logic elig_b,
                                      input logic last_grant,
                                      input logic round_robin);
      logic win;
      if (elig_a && elig_b) begin
         win = round_robin ? ~last_grant : PORT_A;
      end else if (elig_b) begin
         win = PORT_B;
      end else begin
         win = PORT_A;
      end
      return win;
   endfunction

endpackage

// File: rtl/sram_arb_port.sv
// Per-port bookkeeping for the SRAM arbiter: the arm flag that stops a
// level request from being served twice, the eligibility signal seen by the
// grant logic, and the read-data holding register.
module sram_arb_port
   import sram_arb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_n_i,     // synchronous, active low
   input  logic              enable_i,    // level request from the requester
   input  logic              done_i,      // this port's completion pulse
   input  logic              capture_i,   // load rdata_i into the holding register
   input  logic [DATA_W-1:0] rdata_i,
   output logic              eligible_o,
   output logic [DATA_W-1:0] data_o
);

   logic              armed_q, armed_d;
   logic [DATA_W-1:0] data_q, data_d;

   // Arm flag: re-armed whenever the request is seen low, disarmed by the
   // done pulse. A low request wins so a requester that already dropped
   // enable in the done cycle is immediately ready for its next access.
   always_comb begin
      armed_d = armed_q;
      if (!enable_i) begin
         armed_d = 1'b1;
      end else if (done_i) begin
         armed_d = 1'b0;
      end
   end

   // Holding register only changes on a read capture.
   always_comb begin
      data_d = data_q;
      if (capture_i) begin
         data_d = rdata_i;
      end
   end

   // State registers.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         armed_q <= 1'b1;
         data_q  <= '0;
      end else begin
         armed_q <= armed_d;
         data_q  <= data_d;
      end
   end

   assign eligible_o = enable_i & armed_q;
   assign data_o     = data_q;

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single-port SRAM. Port A is the UART host
// path, port B the core/instruction-fetch path. Accesses are serialised
// through IDLE -> ISSUE -> (WAIT) -> DONE; each completed access produces a
// one-cycle done pulse on the owning port. The FSM state is exported on
// dbg_state_o so checkers can observe it directly.
//
// Handshake: x_enable is a level request; a port is served once per
// assertion (it must be seen low for at least one edge before it can be
// served again). x_done is a single-cycle pulse marking completion, and
// x_dataOut is valid from that cycle until the port's next read completes.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int RD_LAT      = 1,
   parameter int ROUND_ROBIN = 1
) (
   input  logic              clk,
   input  logic              rst,          // synchronous, active low
   // port A: UART host path
   input  logic              a_enable,
   input  logic              a_readWrite,
   input  logic [ADDR_W-1:0] a_address,
   input  logic [DATA_W-1:0] a_dataIn,
   output logic [DATA_W-1:0] a_dataOut,
   output logic              a_done,
   // port B: core / instruction-fetch path
   input  logic              b_enable,
   input  logic              b_readWrite,
   input  logic [ADDR_W-1:0] b_address,
   input  logic [DATA_W-1:0] b_dataIn,
   output logic [DATA_W-1:0] b_dataOut,
   output logic              b_done,
   // SRAM side
   output logic              sram_enable,
   output logic              sram_readWrite,
   output logic [ADDR_W-1:0] sram_address,
   output logic [DATA_W-1:0] sram_dataIn,
   input  logic [DATA_W-1:0] sram_dataOut,
   // status
   output logic              busy,
   output logic              grant,
   output logic [1:0]        dbg_state_o
);

   arb_state_t        state_q, state_d;
   logic              grant_q, grant_d;
   logic              last_q, last_d;
   logic              rw_q, rw_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              elig_a, elig_b;
   logic              cap_a, cap_b;
   logic              win;
   logic              in_issue, in_done;

   assign in_issue = (state_q == ST_ISSUE);
   assign in_done  = (state_q == ST_DONE);

   assign a_done = in_done & (grant_q == PORT_A);
   assign b_done = in_done & (grant_q == PORT_B);

   sram_arb_port #(.DATA_W(DATA_W)) u_port_a (
      .clk_i      (clk),
      .rst_n_i    (rst),
      .enable_i   (a_enable),
      .done_i     (a_done),
      .capture_i  (cap_a),
      .rdata_i    (sram_dataOut),
      .eligible_o (elig_a),
      .data_o     (a_dataOut)
   );

   sram_arb_port #(.DATA_W(DATA_W)) u_port_b (
      .clk_i      (clk),
      .rst_n_i    (rst),
      .enable_i   (b_enable),
      .done_i     (b_done),
      .capture_i  (cap_b),
      .rdata_i    (sram_dataOut),
      .eligible_o (elig_b),
      .data_o     (b_dataOut)
   );

   // Next-state logic: arbitration in IDLE, latch the winner's request,
   // count down the read latency, then a single done cycle.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      rw_d    = rw_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      cap_a   = 1'b0;
      cap_b   = 1'b0;
      win     = PORT_A;
      case (state_q)
         ST_IDLE: begin
            if (elig_a || elig_b) begin
               win     = pick_port(elig_a, elig_b, last_q, ROUND_ROBIN != 0);
               grant_d = win;
               last_d  = win;
               // Request fields are frozen here; later changes are ignored.
               rw_d    = (win == PORT_B) ? b_readWrite : a_readWrite;
               addr_d  = (win == PORT_B) ? b_address   : a_address;
               wdata_d = (win == PORT_B) ? b_dataIn    : a_dataIn;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (rw_q) begin
               state_d = ST_DONE;
            end else begin
               cnt_d   = CNT_W'(RD_LAT - 1);
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               // Read data is valid this cycle; hand it to the owning port.
               cap_a   = (grant_q == PORT_A);
               cap_b   = (grant_q == PORT_B);
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset aborts any access in flight. last_grant starts
   // at B so that A wins the first contention.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         grant_q <= PORT_A;
         last_q  <= PORT_B;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
      end
   end

   // SRAM strobe and fields are driven only during ISSUE, zero otherwise.
   always_comb begin
      sram_enable    = in_issue;
      sram_readWrite = in_issue & rw_q;
      sram_address   = in_issue ? addr_q  : '0;
      sram_dataIn    = in_issue ? wdata_q : '0;
   end

   assign busy        = (state_q != ST_IDLE);
   assign grant       = grant_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: three instances (RD_LAT=1 round robin, RD_LAT=4
// round robin, RD_LAT=1 fixed priority), each with its own SRAM model.
// A driver issues requests and pushes the expected SRAM accesses and done
// events into queues; a monitor pops and compares them as the DUT presents
// its outputs.
`timescale 1ns/1ps
module tb_sram_arbiter;

   localparam int AW = 15;
   localparam int DW = 32;
   localparam int NI = 3;

   typedef struct {
      bit            en;
      bit            rw;
      logic [AW-1:0] addr;
      logic [DW-1:0] din;
   } req_t;

   // ---------------- clock / reset / cycle counter ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT signals (one slot per instance) ----------------
   logic [NI-1:0] rst;
   logic [NI-1:0] a_en, a_rw, a_done, b_en, b_rw, b_done;
   logic [NI-1:0] sram_en, sram_rw, busy, grant;
   logic [AW-1:0] a_addr [NI];
   logic [AW-1:0] b_addr [NI];
   logic [AW-1:0] sram_addr [NI];
   logic [DW-1:0] a_din [NI];
   logic [DW-1:0] a_dout [NI];
   logic [DW-1:0] b_din [NI];
   logic [DW-1:0] b_dout [NI];
   logic [DW-1:0] sram_din [NI];
   logic [DW-1:0] sram_dout [NI];
   logic [1:0]    dbg [NI];

   function automatic int rdl_of(int i);
      return (i == 1) ? 4 : 1;
   endfunction

   function automatic bit rr_of(int i);
      return (i == 2) ? 1'b0 : 1'b1;
   endfunction

   // Power-on content of every SRAM location.
   function automatic logic [DW-1:0] dflt(int i, logic [AW-1:0] a);
      return 32'h5A5A0000 + 32'(i) * 32'h00100000 + 32'(a) * 32'd3 + 32'd1;
   endfunction

   // ---------------- DUT instances and SRAM models ----------------
   for (genvar g = 0; g < NI; g++) begin : g_inst
      localparam int RDL = (g == 1) ? 4 : 1;
      localparam int RRB = (g == 2) ? 0 : 1;

      bit [DW-1:0]   dmem [32768];
      bit            wr_ok [32768];
      logic [DW-1:0] pipe [8];

      sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RDL), .ROUND_ROBIN(RRB)) dut (
         .clk            (clk),
         .rst            (rst[g]),
         .a_enable       (a_en[g]),
         .a_readWrite    (a_rw[g]),
         .a_address      (a_addr[g]),
         .a_dataIn       (a_din[g]),
         .a_dataOut      (a_dout[g]),
         .a_done         (a_done[g]),
         .b_enable       (b_en[g]),
         .b_readWrite    (b_rw[g]),
         .b_address      (b_addr[g]),
         .b_dataIn       (b_din[g]),
         .b_dataOut      (b_dout[g]),
         .b_done         (b_done[g]),
         .sram_enable    (sram_en[g]),
         .sram_readWrite (sram_rw[g]),
         .sram_address   (sram_addr[g]),
         .sram_dataIn    (sram_din[g]),
         .sram_dataOut   (sram_dout[g]),
         .busy           (busy[g]),
         .grant          (grant[g]),
         .dbg_state_o    (dbg[g])
      );

      // SRAM model: read data appears RDL edges after the enable edge and
      // is only valid for that one cycle.
      always @(posedge clk) begin
         for (int k = 7; k > 0; k--) pipe[k] <= pipe[k-1];
         pipe[0] <= '0;
         if (sram_en[g]) begin
            if (sram_rw[g]) begin
               dmem[int'(sram_addr[g])]  <= sram_din[g];
               wr_ok[int'(sram_addr[g])] <= 1'b1;
            end else begin
               pipe[0] <= wr_ok[int'(sram_addr[g])] ? dmem[int'(sram_addr[g])]
                                                   : dflt(g, sram_addr[g]);
            end
         end
      end
      assign sram_dout[g] = pipe[RDL-1];
   end

   // ---------------- scoreboard state ----------------
   logic [63:0]   sram_q [NI][$];   // {cycle16, rw, addr15, data32}
   logic [48:0]   exp_q  [NI][$];   // {cycle16, port, dataOut32}
   int            total = 0;
   int            bad = 0;
   bit            end_req = 1'b0;
   int            chk_rst_cyc [NI];

   // reference model (driver side)
   logic [DW-1:0] ref_mem [NI][32768];
   logic [DW-1:0] m_lastrd [NI][2];
   bit            m_last [NI];

   // monitor side
   logic [DW-1:0] held [NI][2];
   int            busy_run [NI];

   task automatic check(string nm, int i, logic [63:0] got, logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s inst=%0d cyc=%0d got=%0h want=%0h", nm, i, cyc, got, want);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [63:0]   e;
      logic [48:0]   x;
      logic          dn;
      logic [DW-1:0] dv;
      for (int i = 0; i < NI; i++) begin
         if (!rst[i]) begin
            held[i][0]  = '0;
            held[i][1]  = '0;
            busy_run[i] = 0;
         end else begin
            if (sram_en[i]) begin
               if (sram_q[i].size() == 0) begin
                  total++; bad++;
                  $display("FAIL sram_unexpected inst=%0d cyc=%0d got_addr=%0h want=none", i, cyc, sram_addr[i]);
               end else begin
                  e = sram_q[i].pop_front();
                  check("sram_access", i, {16'(cyc), sram_rw[i], sram_addr[i], sram_din[i]}, e);
               end
            end else begin
               check("sram_idle_zero", i, {sram_rw[i], sram_addr[i], sram_din[i]}, '0);
            end
            for (int p = 0; p < 2; p++) begin
               dn = (p == 1) ? b_done[i] : a_done[i];
               dv = (p == 1) ? b_dout[i] : a_dout[i];
               if (dn) begin
                  if (exp_q[i].size() == 0) begin
                     total++; bad++;
                     $display("FAIL done_unexpected inst=%0d port=%0d cyc=%0d got=1 want=0", i, p, cyc);
                  end else begin
                     x = exp_q[i].pop_front();
                     check("done_cycle_port", i, {16'(cyc), 1'(p)}, 64'(x[48:32]));
                     check("done_data", i, dv, 64'(x[31:0]));
                     check("grant_at_done", i, grant[i], 64'(p));
                     held[i][p] = x[31:0];
                  end
               end else begin
                  check("held_data", i, dv, held[i][p]);
               end
            end
            if (cyc == chk_rst_cyc[i]) begin
               check("after_reset_busy_grant_state", i, {busy[i], grant[i], dbg[i]}, '0);
            end
            busy_run[i] = busy[i] ? busy_run[i] + 1 : 0;
            if (busy_run[i] == 30) check("busy_timeout", i, 64'(busy_run[i]), 0);
         end
      end
      if (end_req) begin
         for (int i = 0; i < NI; i++) begin
            check("queues_drained", i, 64'(sram_q[i].size() + exp_q[i].size()), 0);
         end
         $display("test done: total=%0d bad=%0d", total, bad);
         $finish;
      end
   end

   // ---------------- driver tasks ----------------
   function automatic req_t mk(bit en, bit rw, logic [AW-1:0] addr, logic [DW-1:0] din);
      req_t r;
      r.en = en; r.rw = rw; r.addr = addr; r.din = din;
      return r;
   endfunction

   function automatic req_t rand_req();
      req_t r;
      r.en   = 1'b1;
      r.rw   = 1'($urandom_range(0, 1));
      r.addr = ($urandom_range(0, 5) == 0) ? 15'h7FFF : 15'($urandom_range(16, 23));
      r.din  = $urandom;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(int i);
      int n = 0;
      while (busy[i] && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic drive_port(int i, int p, req_t q);
      if (p == 0) begin
         a_en[i] = q.en; a_rw[i] = q.rw; a_addr[i] = q.addr; a_din[i] = q.din;
      end else begin
         b_en[i] = q.en; b_rw[i] = q.rw; b_addr[i] = q.addr; b_din[i] = q.din;
      end
   endtask

   task automatic model_reset(int i);
      m_last[i]      = 1'b1;
      m_lastrd[i][0] = '0;
      m_lastrd[i][1] = '0;
   endtask

   // One request (or a simultaneous pair). Expected grant order, SRAM
   // accesses and done cycles are derived from the arbitration rules.
   // hold: cycles the enable stays high past done; early: single requests
   // drop enable right after being sampled.
   task automatic run(int i, req_t ra, req_t rb, int hold, bit early);
      req_t          rq [2];
      int            s [2];
      int            d [2];
      bit            live [2];
      int            order [2];
      int            n, r, start, p;
      logic [DW-1:0] dval;
      wait_idle(i);
      rq[0] = ra; rq[1] = rb;
      r = cyc;
      drive_port(i, 0, ra);
      drive_port(i, 1, rb);
      if (ra.en && rb.en) begin
         order[0] = rr_of(i) ? int'(!m_last[i]) : 0;
         order[1] = 1 - order[0];
         n = 2;
      end else begin
         order[0] = rb.en ? 1 : 0;
         order[1] = 0;
         n = (ra.en || rb.en) ? 1 : 0;
      end
      start = r;
      for (int k = 0; k < n; k++) begin
         p = order[k];
         s[p] = start + 1;
         d[p] = s[p] + 1 + (rq[p].rw ? 0 : rdl_of(i));
         sram_q[i].push_back({16'(s[p]), rq[p].rw, rq[p].addr, rq[p].din});
         if (rq[p].rw) begin
            ref_mem[i][int'(rq[p].addr)] = rq[p].din;
         end else begin
            m_lastrd[i][p] = ref_mem[i][int'(rq[p].addr)];
         end
         dval = m_lastrd[i][p];
         exp_q[i].push_back({16'(d[p]), 1'(p), dval});
         m_last[i] = 1'(p);
         start = d[p] + 1;
      end
      live[0] = ra.en; live[1] = rb.en;
      while (live[0] || live[1]) begin
         tick();
         for (int q = 0; q < 2; q++) begin
            if (live[q]) begin
               if (cyc == s[q]) begin
                  // Fields already latched; scramble them.
                  rq[q].addr = 15'($urandom);
                  rq[q].din  = $urandom;
                  rq[q].rw   = 1'($urandom_range(0, 1));
                  drive_port(i, q, rq[q]);
               end
               if ((early && cyc >= r + 1) || cyc >= d[q] + hold) begin
                  rq[q].en = 1'b0;
                  drive_port(i, q, rq[q]);
                  live[q] = 1'b0;
               end
            end
         end
      end
      tick();
   endtask

   // A read on port A aborted by reset while the arbiter waits for data.
   task automatic reset_abort(int i, logic [AW-1:0] addr);
      logic [DW-1:0] din;
      int r;
      wait_idle(i);
      din = $urandom;
      r = cyc;
      drive_port(i, 0, mk(1'b1, 1'b0, addr, din));
      sram_q[i].push_back({16'(r + 1), 1'b0, addr, din});
      tick();
      a_en[i] = 1'b0;
      tick();
      rst[i] = 1'b0;
      tick();
      rst[i] = 1'b1;
      chk_rst_cyc[i] = cyc;
      model_reset(i);
      repeat (8) tick();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      req_t off;
      off = mk(1'b0, 1'b0, '0, '0);
      for (int i = 0; i < NI; i++) begin
         rst[i] = 1'b0;
         drive_port(i, 0, off);
         drive_port(i, 1, off);
         chk_rst_cyc[i] = -1;
         held[i][0] = '0; held[i][1] = '0;
         busy_run[i] = 0;
         model_reset(i);
         for (int k = 0; k < 32768; k++) ref_mem[i][k] = dflt(i, 15'(k));
      end
      repeat (3) tick();
      for (int i = 0; i < NI; i++) begin
         rst[i] = 1'b1;
         chk_rst_cyc[i] = cyc;
      end
      tick();

      // instance 0: RD_LAT=1, round robin
      run(0, mk(1'b1, 1'b1, 15'h0010, 32'hDEADBEEF), off, 0, 1'b0);
      run(0, mk(1'b1, 1'b0, 15'h0010, $urandom), off, 0, 1'b0);
      repeat (6) tick();
      run(0, mk(1'b1, 1'b0, 15'h0010, $urandom), mk(1'b1, 1'b0, 15'h0011, $urandom), 0, 1'b0);
      run(0, mk(1'b1, 1'b1, 15'h0012, 32'h0BADF00D), off, 0, 1'b0);
      run(0, mk(1'b1, 1'b0, 15'h0012, $urandom), mk(1'b1, 1'b0, 15'h0011, $urandom), 0, 1'b0);
      run(0, off, mk(1'b1, 1'b0, 15'h0013, $urandom), 6, 1'b0);
      run(0, off, mk(1'b1, 1'b0, 15'h0010, $urandom), 0, 1'b0);
      run(0, mk(1'b1, 1'b0, 15'h0012, $urandom), off, 0, 1'b1);

      // instance 2: fixed priority, A always wins
      run(2, mk(1'b1, 1'b0, 15'h0001, $urandom), mk(1'b1, 1'b0, 15'h0002, $urandom), 0, 1'b0);
      run(2, mk(1'b1, 1'b1, 15'h0002, $urandom), mk(1'b1, 1'b0, 15'h0002, $urandom), 0, 1'b0);

      // instance 1: RD_LAT=4, top address, reset during WAIT
      run(1, off, mk(1'b1, 1'b1, 15'h7FFF, 32'h12345678), 0, 1'b0);
      run(1, off, mk(1'b1, 1'b0, 15'h7FFF, $urandom), 0, 1'b0);
      run(1, mk(1'b1, 1'b0, 15'h0020, $urandom), off, 0, 1'b0);
      reset_abort(1, 15'h0021);

      // randomized traffic on every instance
      for (int i = 0; i < NI; i++) begin
         for (int n = 0; n < 40; n++) begin
            req_t ra, rb;
            int kind;
            ra = rand_req();
            rb = rand_req();
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
               run(i, ra, off, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            end else if (kind == 1) begin
               run(i, off, rb, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            end else begin
               run(i, ra, rb, $urandom_range(0, 2), 1'b0);
            end
         end
      end

      repeat (5) tick();
      end_req = 1'b1;
   end

   // Watchdog so the run always terminates.
   initial begin
      #400000;
      $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
